demux3_reg: RTL and testbench

Registered 1-to-3 demultiplexer for the 16-bit datapath, the inverse of `mux3`: it steers one source word to one of three destinations, where `mux3` selects one of three sources. Each destination has a one-entry holding slot with a valid/ready handshake, so a stalled consumer does not corrupt data or block traffic to the other destinations. Select code `2'b11` routes nowhere: the word is accepted, dropped and counted, matching the "nothing" code of `mux3`.

---
 rtl/demux3_pkg.sv | 11 +
 rtl/demux_slot.sv | 27 ++
 rtl/demux3_reg.sv | 61 ++++++
 tb/tb_demux3_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/demux3_pkg.sv
// Shared constants for the 3-way demux and its mux3 counterpart.
// Select codes are shared so both blocks agree on the "nothing" code.
package demux3_pkg;
  localparam int DATA_W    = 16;
  localparam int NUM_SLOTS = 3;

  localparam logic [1:0] SEL_OUT1 = 2'b00;
  localparam logic [1:0] SEL_OUT2 = 2'b01;
  localparam logic [1:0] SEL_OUT3 = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;
endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register; a load wins over a drain on the same edge.
module demux_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              can_load
);
  assign can_load = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux3_reg.sv
// Registered 1-to-3 demux: steers a word into one of three holding slots,
// or drops and counts it on SEL_DROP.
module demux3_reg
  import demux3_pkg::*;
#(
  parameter int DATA_W = demux3_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);
  logic [NUM_SLOTS-1:0]             can_load;
  logic [NUM_SLOTS-1:0]             load;
  logic [NUM_SLOTS-1:0]             slot_valid;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slot_q;
  logic [3:0]                       rdy_by_sel;
  logic                             accept;

  // Drop code always accepts; otherwise only the selected slot decides.
  assign rdy_by_sel = {1'b1, can_load};
  assign in_ready   = rdy_by_sel[in_sel];
  assign accept     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign load[k] = accept && (in_sel == 2'(k));
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .d        (in_data),
      .ready    (out_ready[k]),
      .q        (slot_q[k]),
      .valid    (slot_valid[k]),
      .can_load (can_load[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (accept && in_sel == SEL_DROP && drop_count != '1)
      drop_count <= drop_count + 1'b1;
  end

  assign out1      = slot_q[SEL_OUT1];
  assign out2      = slot_q[SEL_OUT2];
  assign out3      = slot_q[SEL_OUT3];
  assign out_valid = slot_valid;
  assign busy      = |slot_valid;
endmodule

// File: tb/tb_demux3_reg.sv
// Self-checking bench for demux3_reg: directed scenarios plus random traffic
// compared against a slot-occupancy model.
module tb_demux3_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out1, out2, out3;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: each destination is "full or empty" plus last word held.
  bit          mval[3];
  logic [15:0] mdat[3];
  int          mdrop;

  demux3_reg dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out1(out1), .out2(out2),
    .out3(out3), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit exp_rdy();
    if (in_sel == 2'b11) return 1'b1;
    return !mval[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [2:0] exp_vld();
    return {mval[2], mval[1], mval[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = 1'b0;
      mdat[k] = 16'h0000;
    end
    mdrop = 0;
  endtask

  // Apply the handshake rules for the coming edge, then move past it.
  task automatic tick();
    bit acc;
    acc = in_valid && exp_rdy();
    for (int k = 0; k < 3; k++) begin
      if (acc && in_sel == 2'(k)) begin
        mval[k] = 1'b1;
        mdat[k] = in_data;
      end else if (mval[k] && out_ready[k]) begin
        mval[k] = 1'b0;
      end
    end
    if (acc && in_sel == 2'b11 && mdrop < 255) mdrop++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; in_sel = 0; out_ready = 0;
    model_reset();
    #12;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", out_valid); end
    checks++; if ({out1, out2, out3} !== 48'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", out1, out2, out3); end
    checks++; if (drop_count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_cnt_busy got=%0d/%b exp=0/0", drop_count, busy); end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready); end
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill slot 2 and count one drop, then hit reset mid-cycle.
    send(16'h5A5A, 2'b01); tick();
    checks++; if (out_valid !== 3'b010) begin failures++; $display("FAIL prefill_valid got=%b exp=010", out_valid); end
    send(16'hFFFF, 2'b11); tick();
    checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL prefill_drop got=%0d exp=1", drop_count); end
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (out_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b/%b exp=000/0", out_valid, busy); end
    checks++; if (out2 !== 16'h0000) begin failures++; $display("FAIL async_reset_out2 got=%h exp=0000", out2); end
    checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", drop_count); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    logic [15:0] d[3];
    d[0] = 16'hABCD; d[1] = 16'h0123; d[2] = 16'h0000;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      send(d[k], 2'(k));
      checks++; if (in_ready !== 1'b1 || out_valid[k] !== 1'b0) begin failures++; $display("FAIL route_pre%0d rdy=%b vld=%b exp=1/0", k, in_ready, out_valid[k]); end
      tick();
      checks++; if (out_valid !== exp_vld() || out_valid[k] !== 1'b1) begin failures++; $display("FAIL route_valid%0d got=%b exp=%b", k, out_valid, exp_vld()); end
    end
    in_valid = 0; #1;
    checks++; if (out1 !== 16'hABCD || out2 !== 16'h0123 || out3 !== 16'h0000) begin failures++; $display("FAIL route_data got=%h/%h/%h exp=abcd/0123/0000", out1, out2, out3); end
    tick();
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL route_drain got=%b exp=000", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 3'b110;
    send(16'h1111, 2'b00); tick();
    send(16'h2222, 2'b00);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_rdy_2222 got=%b exp=0", in_ready); end
    tick();
    checks++; if (out1 !== 16'h1111 || out_valid[0] !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%b exp=1111/1", out1, out_valid[0]); end
    send(16'h3333, 2'b01);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_iso_rdy got=%b exp=1", in_ready); end
    tick();
    checks++; if (out2 !== 16'h3333 || out_valid[1] !== 1'b1 || out1 !== 16'h1111) begin failures++; $display("FAIL stall_iso got=%h/%b/%h exp=3333/1/1111", out2, out_valid[1], out1); end
    out_ready[0] = 1'b1;
    send(16'h2222, 2'b00);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_rdy got=%b exp=1", in_ready); end
    tick();
    checks++; if (out1 !== 16'h2222 || out_valid[0] !== 1'b1) begin failures++; $display("FAIL stall_release got=%h/%b exp=2222/1", out1, out_valid[0]); end
    in_valid = 0; out_ready = 3'b111; #1; tick();
  endtask

  task automatic test_drain_load();
    out_ready = 3'b000;
    send(16'hAAAA, 2'b10); tick();
    checks++; if (out3 !== 16'hAAAA || out_valid[2] !== 1'b1) begin failures++; $display("FAIL dl_fill got=%h/%b exp=aaaa/1", out3, out_valid[2]); end
    out_ready[2] = 1'b1;
    send(16'hBBBB, 2'b10);
    checks++; if (in_ready !== 1'b1 || out_valid[2] !== 1'b1) begin failures++; $display("FAIL dl_rdy got=%b/%b exp=1/1", in_ready, out_valid[2]); end
    tick();
    checks++; if (out3 !== 16'hBBBB || out_valid[2] !== 1'b1) begin failures++; $display("FAIL dl_replace got=%h/%b exp=bbbb/1", out3, out_valid[2]); end
    in_valid = 0; #1; tick();
    checks++; if (out_valid[2] !== 1'b0) begin failures++; $display("FAIL dl_drain got=%b exp=0", out_valid[2]); end
  endtask

  task automatic test_drop();
    logic [15:0] snap[3];
    for (int k = 0; k < 3; k++) snap[k] = mdat[k];
    for (int i = 0; i < 300; i++) begin
      out_ready = 3'($urandom);
      send(16'($urandom), 2'b11);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_rdy i=%0d got=%b exp=1", i, in_ready); end
      tick();
      if (i == 253) begin
        checks++; if (drop_count !== 8'(mdrop)) begin failures++; $display("FAIL drop_mid got=%0d exp=%0d", drop_count, mdrop); end
      end
    end
    in_valid = 0; #1;
    checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_count); end
    checks++; if (out_valid !== 3'b000 || out1 !== snap[0] || out2 !== snap[1] || out3 !== snap[2]) begin failures++; $display("FAIL drop_slots got=%b %h/%h/%h exp=000 %h/%h/%h", out_valid, out1, out2, out3, snap[0], snap[1], snap[2]); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 2'($urandom);
      in_data   = 16'($urandom);
      out_ready = 3'($urandom);
      #1;
      checks++; if (in_ready !== exp_rdy()) begin failures++; errs++; if (errs < 10) $display("FAIL rand_rdy i=%0d got=%b exp=%b", i, in_ready, exp_rdy()); end
      tick();
      checks++;
      if (out_valid !== exp_vld() || out1 !== mdat[0] || out2 !== mdat[1] || out3 !== mdat[2] ||
          drop_count !== 8'(mdrop) || busy !== (|exp_vld())) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_state i=%0d got=%b %h/%h/%h cnt=%0d busy=%b exp=%b %h/%h/%h cnt=%0d",
          i, out_valid, out1, out2, out3, drop_count, busy, exp_vld(), mdat[0], mdat[1], mdat[2], mdrop);
      end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_drain_load();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
